// File: rtl/tanh_deriv_pkg.sv
// Shared types and constants for the serial tanh-derivative (backward pass) block.
package tanh_deriv_pkg;

    localparam int DEF_N    = 16;
    localparam int DEF_SIZE = 100;
    localparam int DEF_FRAC = 12;
    localparam int DEF_ONE  = 1 << DEF_FRAC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bit position of the LSB of lane idx in a packed bus of n-bit lanes.
    function automatic int lane_lsb(input int idx, input int n);
        return idx * n;
    endfunction

endpackage

// File: rtl/tanh_deriv_serial_pipe.sv
// Three-stage datapath: s1 = y^2, s2 = clamp(ONE - s1), d = e * s2.
// The retire port exposes the value being loaded into the output stage this cycle.
module tanh_deriv_pipe #(
    parameter int N    = 16,
    parameter int FRAC = 12,
    parameter int IW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [IW-1:0]       issue_idx,
    input  logic signed [N-1:0] y,
    input  logic signed [N-1:0] e,
    output logic                ret_valid,
    output logic [IW-1:0]       ret_idx,
    output logic [N-1:0]        ret_d,
    output logic                d_valid,
    output logic [IW-1:0]       d_idx,
    output logic [N-1:0]        d_out
);

    localparam logic signed [2*N-1:0] ONE_W = (2*N)'(1) << FRAC;
    localparam logic signed [N-1:0]   ONE_N = N'(1) << FRAC;

    logic signed [2*N-1:0] y_ext;
    logic signed [2*N-1:0] s1_next;
    logic signed [2*N-1:0] s1_reg;
    logic signed [N-1:0]   e1_reg;
    logic                  v1_reg;
    logic [IW-1:0]         idx1_reg;

    logic signed [N-1:0]   s2_next;
    logic signed [N-1:0]   s2_reg;
    logic signed [N-1:0]   e2_reg;
    logic                  v2_reg;
    logic [IW-1:0]         idx2_reg;

    logic signed [2*N-1:0] e_ext;
    logic signed [2*N-1:0] s2_ext;
    logic signed [2*N-1:0] prod;

    logic                  v3_reg;
    logic [IW-1:0]         idx3_reg;
    logic [N-1:0]          d3_reg;

    assign y_ext   = {{N{y[N-1]}}, y};
    assign s1_next = (y_ext * y_ext) >>> FRAC;

    // |y| >= 1.0 would make 1 - y^2 negative; the derivative is clamped to zero instead.
    assign s2_next = (s1_reg >= ONE_W) ? '0 : (ONE_N - s1_reg[N-1:0]);

    assign e_ext  = {{N{e2_reg[N-1]}}, e2_reg};
    assign s2_ext = {{N{s2_reg[N-1]}}, s2_reg};
    assign prod   = e_ext * s2_ext;

    assign ret_valid = v2_reg;
    assign ret_idx   = idx2_reg;
    assign ret_d     = N'(prod >>> FRAC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg   <= '0;
            e1_reg   <= '0;
            v1_reg   <= 1'b0;
            idx1_reg <= '0;
            s2_reg   <= '0;
            e2_reg   <= '0;
            v2_reg   <= 1'b0;
            idx2_reg <= '0;
            v3_reg   <= 1'b0;
            idx3_reg <= '0;
            d3_reg   <= '0;
        end else begin
            s1_reg   <= s1_next;
            e1_reg   <= e;
            v1_reg   <= issue_valid;
            idx1_reg <= issue_idx;
            s2_reg   <= s2_next;
            e2_reg   <= e1_reg;
            v2_reg   <= v1_reg;
            idx2_reg <= idx1_reg;
            v3_reg   <= v2_reg;
            // Index and value hold their last lane between results.
            if (v2_reg) begin
                idx3_reg <= idx2_reg;
                d3_reg   <= ret_d;
            end
        end
    end

    assign d_valid = v3_reg;
    assign d_idx   = idx3_reg;
    assign d_out   = d3_reg;

endmodule

// File: rtl/tanh_deriv_serial.sv
// Serial backward-pass delta = E * (1 - Y^2) over SIZE lanes through one shared pipeline,
// streamed per lane and collected into the D register bank.
module tanh_deriv_serial
    import tanh_deriv_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int SIZE = DEF_SIZE,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SIZE-1:0]         y_ready,
    input  logic [N*SIZE-1:0]       Y,
    input  logic [N*SIZE-1:0]       E,
    output logic                    busy,
    output logic                    done,
    output logic                    d_valid,
    output logic [$clog2(SIZE):0]   d_idx,
    output logic [N-1:0]            d_out,
    output logic [N*SIZE-1:0]       D
);

    localparam int IW = $clog2(SIZE) + 1;

    state_t              state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic                issue_valid;
    logic                accept;

    logic signed [N-1:0] y_lane [SIZE];
    logic signed [N-1:0] e_lane [SIZE];
    logic signed [N-1:0] y_issue;
    logic signed [N-1:0] e_issue;

    logic                ret_valid;
    logic [IW-1:0]       ret_idx;
    logic [N-1:0]        ret_d;
    logic [N-1:0]        d_bank [SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_lane
            assign y_lane[gi] = Y[lane_lsb(gi, N) +: N];
            assign e_lane[gi] = E[lane_lsb(gi, N) +: N];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_bank[gi] <= '0;
                end else if (ret_valid && (ret_idx == IW'(gi))) begin
                    d_bank[gi] <= ret_d;
                end
            end

            assign D[lane_lsb(gi, N) +: N] = d_bank[gi];
        end
    endgenerate

    assign accept  = start && (&y_ready);
    assign y_issue = y_lane[idx_reg];
    assign e_issue = e_lane[idx_reg];
    assign done    = d_valid && (d_idx == IW'(SIZE - 1));
    assign busy    = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        issue_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    idx_next   = '0;
                end
            end
            RUN: begin
                issue_valid = 1'b1;
                if (idx_reg == IW'(SIZE - 1)) begin
                    state_next = DRAIN;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DRAIN: begin
                // The last lane retiring empties the pipe; a waiting start chains straight on.
                if (done) begin
                    if (accept) begin
                        state_next = RUN;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    tanh_deriv_pipe #(
        .N    (N),
        .FRAC (FRAC),
        .IW   (IW)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_idx   (idx_reg),
        .y           (y_issue),
        .e           (e_issue),
        .ret_valid   (ret_valid),
        .ret_idx     (ret_idx),
        .ret_d       (ret_d),
        .d_valid     (d_valid),
        .d_idx       (d_idx),
        .d_out       (d_out)
    );

endmodule

// File: tb/tb_tanh_deriv_serial.sv
// Directed bench for tanh_deriv_serial: a SIZE=100 instance plus a SIZE=1 instance,
// checked cycle by cycle against hand-computed deltas.
module tb_tanh_deriv_serial;

    localparam int N    = 16;
    localparam int SIZE = 100;
    localparam int FRAC = 12;
    localparam int IW   = $clog2(SIZE) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [SIZE-1:0]   y_ready;
    logic [N*SIZE-1:0] Y;
    logic [N*SIZE-1:0] E;
    logic              busy;
    logic              done;
    logic              d_valid;
    logic [IW-1:0]     d_idx;
    logic [N-1:0]      d_out;
    logic [N*SIZE-1:0] D;

    logic              start1;
    logic [0:0]        y_ready1;
    logic [N-1:0]      Y1;
    logic [N-1:0]      E1;
    logic              busy1;
    logic              done1;
    logic              d_valid1;
    logic [0:0]        d_idx1;
    logic [N-1:0]      d_out1;
    logic [N-1:0]      D1;

    int compared   = 0;
    int mismatched = 0;
    logic [N-1:0] exp_d [SIZE];

    always #5 clk = ~clk;

    tanh_deriv_serial #(.N(N), .SIZE(SIZE), .FRAC(FRAC)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .y_ready (y_ready),
        .Y       (Y),
        .E       (E),
        .busy    (busy),
        .done    (done),
        .d_valid (d_valid),
        .d_idx   (d_idx),
        .d_out   (d_out),
        .D       (D)
    );

    tanh_deriv_serial #(.N(N), .SIZE(1), .FRAC(FRAC)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .y_ready (y_ready1),
        .Y       (Y1),
        .E       (E1),
        .busy    (busy1),
        .done    (done1),
        .d_valid (d_valid1),
        .d_idx   (d_idx1),
        .d_out   (d_out1),
        .D       (D1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [N-1:0] y, input logic [N-1:0] e, input logic [N-1:0] d);
        for (int i = 0; i < SIZE; i++) begin
            Y[N*i +: N] = y;
            E[N*i +: N] = e;
            exp_d[i]    = d;
        end
    endtask

    task automatic set_lane(input int i, input logic [N-1:0] y, input logic [N-1:0] e,
                            input logic [N-1:0] d);
        Y[N*i +: N] = y;
        E[N*i +: N] = e;
        exp_d[i]    = d;
    endtask

    task automatic check_bank();
        for (int i = 0; i < SIZE; i++) begin
            check($sformatf("D[%0d]", i), 32'(D[N*i +: N]), 32'(exp_d[i]));
        end
    endtask

    // pre: start already raised in the previous done cycle; chain: raise start in this
    // pass's done cycle; poke: pulse start mid-pass (must be ignored).
    task automatic run_pass(input string name, input bit pre, input bit chain, input bit poke);
        bit ev;
        $display("pass %s", name);
        if (!pre) start = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy_at_T"}, 32'(busy), 32'd1);
        check({name, " d_valid_at_T"}, 32'(d_valid), 32'd0);
        for (int k = 1; k <= SIZE + 2; k++) begin
            tick();
            if (poke && k == 10) start = 1'b1;
            if (poke && k == 11) start = 1'b0;
            ev = (k >= 3);
            check($sformatf("%s d_valid k=%0d", name, k), 32'(d_valid), 32'(ev));
            check($sformatf("%s done k=%0d", name, k), 32'(done), 32'(k == SIZE + 2));
            check($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'd1);
            if (ev) begin
                check($sformatf("%s d_idx k=%0d", name, k), 32'(d_idx), 32'(k - 3));
                check($sformatf("%s d_out lane %0d", name, k - 3), 32'(d_out), 32'(exp_d[k - 3]));
            end
            if (chain && k == SIZE + 2) start = 1'b1;
        end
        check_bank();
        if (!chain) begin
            tick();
            check({name, " busy_end"}, 32'(busy), 32'd0);
            check({name, " d_valid_end"}, 32'(d_valid), 32'd0);
            check({name, " done_end"}, 32'(done), 32'd0);
        end
    endtask

    task automatic set_mixed();
        for (int i = 0; i < SIZE; i++) begin
            case (i % 5)
                0: set_lane(i, 16'h7FFF, 16'h7FFF, 16'h0000);
                1: set_lane(i, 16'h0000, 16'hFFFF, 16'hFFFF);
                2: set_lane(i, 16'd2896, 16'hFFFF, 16'hFFFF);
                3: set_lane(i, 16'd2048, 16'd4096, 16'd3072);
                default: set_lane(i, 16'h0000, 16'(i * 16), 16'(i * 16));
            endcase
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;
        y_ready  = '1;
        y_ready1 = 1'b1;
        Y        = '0;
        E        = '0;
        Y1       = '0;
        E1       = '0;

        tick();
        tick();
        $display("reset state");
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst d_valid", 32'(d_valid), 32'd0);
        check("rst d_idx", 32'(d_idx), 32'd0);
        check("rst d_out", 32'(d_out), 32'd0);
        check("rst D_zero", 32'(D == '0), 32'd1);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst D1", 32'(D1), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("size1 pass");
        Y1 = 16'd2048;
        E1 = 16'd4096;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s1 busy_at_T", 32'(busy1), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check($sformatf("s1 d_valid k=%0d", k), 32'(d_valid1), 32'd0);
            check($sformatf("s1 done k=%0d", k), 32'(done1), 32'd0);
        end
        tick();
        check("s1 d_valid k=3", 32'(d_valid1), 32'd1);
        check("s1 done k=3", 32'(done1), 32'd1);
        check("s1 d_idx", 32'(d_idx1), 32'd0);
        check("s1 d_out", 32'(d_out1), 32'd3072);
        check("s1 D", 32'(D1), 32'd3072);
        tick();
        check("s1 busy_end", 32'(busy1), 32'd0);
        check("s1 d_valid_end", 32'(d_valid1), 32'd0);

        set_all(16'h0000, 16'd2048, 16'd2048);
        run_pass("t1_half", 1'b0, 1'b0, 1'b0);

        set_all(16'd2048, 16'd4096, 16'd3072);
        run_pass("t2_y_half", 1'b0, 1'b0, 1'b0);
        set_all(16'hF000, 16'd4096, 16'h0000);
        run_pass("t2_y_minus1", 1'b0, 1'b0, 1'b0);

        set_mixed();
        run_pass("t3_mixed", 1'b0, 1'b0, 1'b0);

        $display("not-ready start");
        y_ready[5] = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4 busy k=%0d", k), 32'(busy), 32'd0);
            check($sformatf("t4 d_valid k=%0d", k), 32'(d_valid), 32'd0);
        end
        start = 1'b0;
        y_ready[5] = 1'b1;
        set_all(16'd2048, 16'd4096, 16'd3072);
        run_pass("t4_ready", 1'b0, 1'b0, 1'b0);

        set_mixed();
        run_pass("t5_poke", 1'b0, 1'b1, 1'b1);
        run_pass("t5_chain", 1'b1, 1'b0, 1'b0);

        $display("reset mid-pass");
        set_all(16'h0000, 16'd2048, 16'd2048);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 43; k++) tick();
        check("t6 d_valid lane40", 32'(d_valid), 32'd1);
        check("t6 d_idx lane40", 32'(d_idx), 32'd40);
        rst_n = 1'b0;
        tick();
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 d_valid", 32'(d_valid), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        check("t6 d_idx", 32'(d_idx), 32'd0);
        check("t6 d_out", 32'(d_out), 32'd0);
        check("t6 D_zero", 32'(D == '0), 32'd1);
        rst_n = 1'b1;
        tick();
        check("t6 d_valid_flushed", 32'(d_valid), 32'd0);
        set_all(16'd2048, 16'd4096, 16'd3072);
        run_pass("t6_after_reset", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
